// File: rtl/ctrl_pkg.sv
// Shared constants for the 8-bit processor control sequencer: opcodes, microstep
// indices, control-word bit positions and the per-opcode last-step lookup.
package ctrl_pkg;

  localparam int STEP_W = 3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'he;
  localparam logic [3:0] OP_HLT = 4'hf;

  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;

  localparam int CW_PC_INC  = 0;
  localparam int CW_PC_OUT  = 1;
  localparam int CW_JUMP    = 2;
  localparam int CW_MAR_IN  = 3;
  localparam int CW_RAM_IN  = 4;
  localparam int CW_RAM_OUT = 5;
  localparam int CW_IR_IN   = 6;
  localparam int CW_IR_OUT  = 7;
  localparam int CW_A_IN    = 8;
  localparam int CW_A_OUT   = 9;
  localparam int CW_B_IN    = 10;
  localparam int CW_ALU_EN  = 11;
  localparam int CW_ALU_SUB = 12;
  localparam int CW_FLAG_EN = 13;
  localparam int CW_OUT_IN  = 14;
  localparam int CW_W       = 15;

  // Last microstep that carries any control activity for the opcode.
  function automatic logic [STEP_W-1:0] last_step(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA:                               last_step = T3;
      OP_ADD, OP_SUB:                               last_step = T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = T2;
      default:                                      last_step = T1;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_step_counter.sv
// Microstep counter with sticky halt flag; advances on run, wraps after the
// last step (or early on early_end), freezes once halted until clr.
module step_counter
  import ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic              halt_req,
  input  logic              early_end,
  output logic [STEP_W-1:0] step,
  output logic              halted
);

  localparam logic [STEP_W-1:0] LAST = STEP_W'(NUM_STEPS - 1);

  always_ff @(posedge clk) begin
    if (clr) begin
      step   <= '0;
      halted <= 1'b0;
    end else if (run && !halted) begin
      // Halting leaves step parked on the HLT step rather than advancing.
      if (halt_req) begin
        halted <= 1'b1;
      end else if (early_end || step == LAST) begin
        step <= '0;
      end else begin
        step <= step + 1'b1;
      end
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcode decode for the 8-bit processor: one combinational control word per
// step. Optional SEQ_EARLY_END_EN ends each instruction after its last busy step.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OP_W      = 4,
  parameter int NUM_STEPS = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic [OP_W-1:0]   opcode,
  input  logic              carry,
  input  logic              is_zero,
  output logic [STEP_W-1:0] step,
  output logic              halted,
  output logic              pc_inc,
  output logic              pc_out,
  output logic              jump,
  output logic              mar_in,
  output logic              ram_in,
  output logic              ram_out,
  output logic              ir_in,
  output logic              ir_out,
  output logic              a_in,
  output logic              a_out,
  output logic              b_in,
  output logic              alu_en,
  output logic              alu_sub,
  output logic              flag_en,
  output logic              out_in
);

  logic [CW_W-1:0] cw;
  logic            halt_req;
  logic            early_end;

  assign halt_req = (step == T2) && (opcode == OP_HLT);

`ifdef SEQ_EARLY_END_EN
  assign early_end = (step == last_step(opcode));
`else
  assign early_end = 1'b0;
`endif

  step_counter #(.NUM_STEPS(NUM_STEPS)) u_step_counter (
    .clk       (clk),
    .clr       (clr),
    .run       (run),
    .halt_req  (halt_req),
    .early_end (early_end),
    .step      (step),
    .halted    (halted)
  );

  always_comb begin
    cw = '0;
    case (step)
      T0: begin
        cw[CW_PC_OUT] = 1'b1;
        cw[CW_MAR_IN] = 1'b1;
      end
      T1: begin
        cw[CW_RAM_OUT] = 1'b1;
        cw[CW_IR_IN]   = 1'b1;
        cw[CW_PC_INC]  = 1'b1;
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_MAR_IN] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_A_IN]   = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_JUMP]   = 1'b1;
          end
          OP_JC: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_JUMP]   = carry;
          end
          OP_JZ: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_JUMP]   = is_zero;
          end
          OP_OUT: begin
            cw[CW_A_OUT]  = 1'b1;
            cw[CW_OUT_IN] = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_A_IN]    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_B_IN]    = 1'b1;
          end
          OP_STA: begin
            cw[CW_A_OUT]  = 1'b1;
            cw[CW_RAM_IN] = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw[CW_ALU_EN]  = 1'b1;
          cw[CW_A_IN]    = 1'b1;
          cw[CW_FLAG_EN] = 1'b1;
          cw[CW_ALU_SUB] = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
    if (clr || halted) begin
      cw = '0;
    end
  end

  assign pc_inc  = cw[CW_PC_INC];
  assign pc_out  = cw[CW_PC_OUT];
  assign jump    = cw[CW_JUMP];
  assign mar_in  = cw[CW_MAR_IN];
  assign ram_in  = cw[CW_RAM_IN];
  assign ram_out = cw[CW_RAM_OUT];
  assign ir_in   = cw[CW_IR_IN];
  assign ir_out  = cw[CW_IR_OUT];
  assign a_in    = cw[CW_A_IN];
  assign a_out   = cw[CW_A_OUT];
  assign b_in    = cw[CW_B_IN];
  assign alu_en  = cw[CW_ALU_EN];
  assign alu_sub = cw[CW_ALU_SUB];
  assign flag_en = cw[CW_FLAG_EN];
  assign out_in  = cw[CW_OUT_IN];

endmodule
